// File: rtl/mem_access_stage.sv
// MEM stage: non-memory instructions pass straight through; loads and stores stall the
// pipeline over a req/ack data-memory handshake. Optional REQ timeout: MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic [15:0] ex_alu_result,
    input  logic [15:0] ex_write_data,
    input  logic [2:0]  ex_write_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        mem_reg_write,
    output logic        mem_mem_to_reg,
    output logic [15:0] mem_alu_result,
    output logic [15:0] mem_read_data,
    output logic [2:0]  mem_write_reg,
    output logic        mem_stall,
    output logic        mem_timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [2:0]  write_reg_q, write_reg_d;
    logic [15:0] rdata_q, rdata_d;
    logic        access;
    logic        abort;

    assign access = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q;

    // Ack has priority over an expiring counter.
    assign abort = (state_q == S_REQ) && !dmem_ack && (cnt_q == TO_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = 8'd0;
        end else if (state_q == S_REQ) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= abort;
        end
    end

    assign mem_timeout_err = err_q;
`else
    assign abort           = 1'b0;
    assign mem_timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (access) state_d = S_REQ;
            S_REQ:   if (dmem_ack || abort) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request and latched instruction fields; read data only moves on load completion.
    always_comb begin
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        write_reg_d  = write_reg_q;
        rdata_d      = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    req_d        = 1'b1;
                    we_d         = ex_mem_write;
                    addr_d       = ex_alu_result;
                    wdata_d      = ex_write_data;
                    reg_write_d  = ex_reg_write;
                    mem_to_reg_d = ex_mem_to_reg;
                    write_reg_d  = ex_write_reg;
                end
            end
            S_REQ: begin
                if (dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = dmem_rdata;
                    end
                end else if (abort) begin
                    req_d   = 1'b0;
                    rdata_d = 16'hDEAD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            write_reg_q  <= 3'd0;
            rdata_q      <= 16'h0000;
        end else begin
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            write_reg_q  <= write_reg_d;
            rdata_q      <= rdata_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    always_comb begin
        mem_stall      = 1'b0;
        mem_reg_write  = ex_valid & ex_reg_write;
        mem_mem_to_reg = ex_mem_to_reg;
        mem_alu_result = ex_alu_result;
        mem_read_data  = 16'h0000;
        mem_write_reg  = ex_write_reg;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    mem_stall     = 1'b1;
                    mem_reg_write = 1'b0;
                end
            end
            S_REQ: begin
                mem_stall      = 1'b1;
                mem_reg_write  = 1'b0;
                mem_mem_to_reg = mem_to_reg_q;
                mem_alu_result = addr_q;
                mem_read_data  = rdata_q;
                mem_write_reg  = write_reg_q;
            end
            S_DONE: begin
                mem_reg_write  = reg_write_q & ~we_q & ~mem_timeout_err;
                mem_mem_to_reg = mem_to_reg_q;
                mem_alu_result = addr_q;
                mem_read_data  = rdata_q;
                mem_write_reg  = write_reg_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed plan cases plus randomized
// instruction stream against a transaction-level memory/pipeline model.
module tb_mem_access_stage;

    localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
    localparam int KMAX = TO - 1;
`else
    localparam int KMAX = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic        ex_reg_write = 1'b0, ex_mem_to_reg = 1'b0;
    logic [15:0] ex_alu_result = '0, ex_write_data = '0;
    logic [2:0]  ex_write_reg = '0;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [15:0] dmem_rdata = '0;
    logic        mem_reg_write, mem_mem_to_reg;
    logic [15:0] mem_alu_result, mem_read_data;
    logic [2:0]  mem_write_reg;
    logic        mem_stall, mem_timeout_err;

    int checks = 0;
    int failures = 0;
    int txn = 0;

    logic [15:0] mem_model [16];
    logic [15:0] last_rdata = 16'h0000;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
        .ex_write_reg(ex_write_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
        .mem_write_reg(mem_write_reg), .mem_stall(mem_stall),
        .mem_timeout_err(mem_timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Runs one instruction starting just after a falling edge; returns just after a falling edge.
    // k = cycles after dmem_req rises before the memory acks.
    task automatic run_instr(input logic v, input logic rd, input logic wr, input logic rw,
                             input logic m2r, input logic [15:0] alu, input logic [15:0] wd,
                             input logic [2:0] wreg, input int k);
        bit          is_acc;
        bit          exp_to;
        int          exp_reqs;
        int          stalls;
        logic [15:0] exp_rd;
        is_acc = v && (rd || wr);
`ifdef MEM_TIMEOUT_EN
        exp_to = (k >= TO);
`else
        exp_to = 1'b0;
`endif
        exp_reqs = exp_to ? TO : k + 1;
        ex_valid = v; ex_mem_read = rd; ex_mem_write = wr;
        ex_reg_write = rw; ex_mem_to_reg = m2r;
        ex_alu_result = alu; ex_write_data = wd; ex_write_reg = wreg;
        dmem_ack = 1'($urandom);
        dmem_rdata = 16'($urandom);
        #1;
        check("idle_req", dmem_req, 0);
        check("idle_err", mem_timeout_err, 0);
        if (!is_acc) begin
            check("pass_stall", mem_stall, 0);
            check("pass_alu", mem_alu_result, alu);
            check("pass_wreg", mem_write_reg, wreg);
            check("pass_rw", mem_reg_write, v & rw);
            check("pass_m2r", mem_mem_to_reg, m2r);
            check("pass_rdata", mem_read_data, 0);
            @(negedge clk);
            dmem_ack = 1'b0;
            $display("txn %0d pass v=%b alu=%h wreg=%0d", txn, v, alu, wreg);
            txn++;
            return;
        end
        check("acc_stall", mem_stall, 1);
        check("acc_rw", mem_reg_write, 0);
        stalls = 1;
        for (int i = 0; i < exp_reqs; i++) begin
            @(negedge clk);
            dmem_ack = (i == k);
            dmem_rdata = (i == k) ? mem_model[alu[3:0]] : 16'($urandom);
            #1;
            check("req_high", dmem_req, 1);
            check("req_we", dmem_we, wr);
            check("req_addr", dmem_addr, alu);
            check("req_wdata", dmem_wdata, wd);
            check("req_rw", mem_reg_write, 0);
            if (mem_stall) stalls++;
        end
        @(negedge clk);
        dmem_ack = 1'($urandom);
        dmem_rdata = 16'($urandom);
        #1;
        if (exp_to) exp_rd = 16'hDEAD;
        else if (wr) exp_rd = last_rdata;
        else exp_rd = mem_model[alu[3:0]];
        if (mem_stall) stalls++;
        check("done_stall", mem_stall, 0);
        check("done_req", dmem_req, 0);
        check("done_rw", mem_reg_write, rw & ~wr & ~exp_to);
        check("done_rdata", mem_read_data, exp_rd);
        check("done_alu", mem_alu_result, alu);
        check("done_wreg", mem_write_reg, wreg);
        check("done_m2r", mem_mem_to_reg, m2r);
        check("done_err", mem_timeout_err, exp_to);
        check("stall_cycles", stalls, exp_reqs + 1);
        if (!exp_to) begin
            if (wr) mem_model[alu[3:0]] = wd;
            else last_rdata = exp_rd;
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        $display("txn %0d %s addr=%h k=%0d stalls=%0d rdata=%h", txn,
                 wr ? "store" : "load", alu, k, stalls, mem_read_data);
        txn++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_model[i] = 16'($urandom);
        mem_model[0] = 16'hBEEF;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_err", mem_timeout_err, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_rw", mem_reg_write, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(1, 0, 0, 1, 0, 16'h1234, 16'h0000, 3'd3, 0);
        run_instr(1, 1, 0, 1, 1, 16'h0040, 16'h0000, 3'd5, 0);
        run_instr(1, 0, 1, 1, 0, 16'h0100, 16'hA5A5, 3'd2, 3);
        run_instr(1, 1, 1, 1, 0, 16'h0107, 16'h5A5A, 3'd1, 1);
        run_instr(0, 1, 1, 1, 1, 16'h0055, 16'h1111, 3'd4, 0);

        // Reset asserted while a load sits in REQ
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_reg_write = 1;
        ex_mem_to_reg = 1; ex_alu_result = 16'h0042; ex_write_reg = 3'd6; dmem_ack = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("abort_req_before", dmem_req, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_req", dmem_req, 0);
        check("abort_stall", mem_stall, 1);
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 16'h0000;
        run_instr(1, 0, 0, 1, 0, 16'h7777, 16'h0000, 3'd7, 0);
        run_instr(1, 0, 1, 1, 1, 16'h0203, 16'hC3C3, 3'd2, 2);

`ifdef MEM_TIMEOUT_EN
        run_instr(1, 1, 0, 1, 1, 16'h0009, 16'h0000, 3'd1, 99);
        run_instr(1, 1, 0, 1, 1, 16'h0009, 16'h0000, 3'd1, TO - 1);
`endif

        for (int n = 0; n < 200; n++) begin
            logic v, rd, wr;
            v  = ($urandom_range(0, 7) != 0);
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 2) == 0);
            run_instr(v, rd, wr, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                      3'($urandom), $urandom_range(0, KMAX));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
